// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer.
//   - FSM state encoding, also driven out on the 'state' status port
//   - counter width helper sized from the longest timed interval
package pll_seq_pkg;

    localparam logic [1:0] PLL_RST   = 2'd0;  // PLL held in reset for HOLD_CYCLES
    localparam logic [1:0] WAIT_LOCK = 2'd1;  // waiting for lock, bounded by LOCK_TIMEOUT
    localparam logic [1:0] STABLE    = 2'd2;  // lock must stay high for STABLE_CYCLES
    localparam logic [1:0] RUN       = 2'd3;  // system reset released

    // The counter only ever has to reach (limit - 1) of the state it is in,
    // so clog2 of the largest limit is enough. Never return less than 1 bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pll_reset_seq_sync_ff.sv
// Multi-stage synchroniser with asynchronous active-low clear.
// Ports:
//   clock   - destination clock
//   reset_n - asynchronous active-low clear, forces every stage to 0
//   d       - asynchronous input
//   q       - synchronised output, STAGES clocks of latency
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset / lock sequencer. Runs on the PLL reference clock so it keeps
// working while the PLL output is dead.
//
// state | meaning
// ------+------------------------------------------------------------
//   0   | PLL_RST   : pll_reset_n low for HOLD_CYCLES
//   1   | WAIT_LOCK : PLL released, waiting for lock (LOCK_TIMEOUT)
//   2   | STABLE    : lock seen, must hold for STABLE_CYCLES
//   3   | RUN       : sys_reset_n released; lock loss restarts the PLL
//
// Ports:
//   clock         - 100 MHz reference clock
//   reset_n       - asynchronous active-low reset
//   locked        - PLL lock, asynchronous to clock
//   soft_restart  - single-cycle synchronous restart request (highest priority)
//   pll_reset_n   - to PLL RESETB, low holds the PLL in reset
//   sys_reset_n   - system reset, async assert / sync deassert
//   state         - current FSM state
//   timeout_count - saturating count of lock timeouts
//   loss_count    - saturating count of lock losses while in RUN
module pll_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int HOLD_CYCLES   = 16,
    parameter int LOCK_TIMEOUT  = 10000,
    parameter int STABLE_CYCLES = 1024,
    parameter int SYNC_STAGES   = 2,
    parameter int CNT_W         = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             locked,
    input  logic             soft_restart,
    output logic             pll_reset_n,
    output logic             sys_reset_n,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] timeout_count,
    output logic [CNT_W-1:0] loss_count
);

    localparam int CIW = cnt_width(HOLD_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

    localparam logic [CIW-1:0] HOLD_LAST    = CIW'(HOLD_CYCLES - 1);
    localparam logic [CIW-1:0] TIMEOUT_LAST = CIW'(LOCK_TIMEOUT - 1);
    localparam logic [CIW-1:0] STABLE_LAST  = CIW'(STABLE_CYCLES - 1);

    logic           locked_s;
    logic [CIW-1:0] cnt;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (locked),
        .q       (locked_s)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= PLL_RST;
            cnt           <= '0;
            pll_reset_n   <= 1'b0;
            sys_reset_n   <= 1'b0;
            timeout_count <= '0;
            loss_count    <= '0;
        end else if (soft_restart) begin
            // Overrides any transition due this cycle; not counted as an event.
            state       <= PLL_RST;
            cnt         <= '0;
            pll_reset_n <= 1'b0;
            sys_reset_n <= 1'b0;
        end else begin
            case (state)
                PLL_RST: begin
                    pll_reset_n <= 1'b0;
                    sys_reset_n <= 1'b0;
                    if (cnt == HOLD_LAST) begin
                        state       <= WAIT_LOCK;
                        cnt         <= '0;
                        pll_reset_n <= 1'b1;
                    end else begin
                        cnt <= cnt + CIW'(1);
                    end
                end

                WAIT_LOCK: begin
                    if (locked_s) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state       <= PLL_RST;
                        cnt         <= '0;
                        pll_reset_n <= 1'b0;
                        if (timeout_count != '1) begin
                            timeout_count <= timeout_count + CNT_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CIW'(1);
                    end
                end

                STABLE: begin
                    // A drop here is just an unstable lock, not a loss event.
                    if (!locked_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state       <= RUN;
                        sys_reset_n <= 1'b1;
                    end else begin
                        cnt <= cnt + CIW'(1);
                    end
                end

                RUN: begin
                    if (!locked_s) begin
                        state       <= PLL_RST;
                        cnt         <= '0;
                        pll_reset_n <= 1'b0;
                        sys_reset_n <= 1'b0;
                        if (loss_count != '1) begin
                            loss_count <= loss_count + CNT_W'(1);
                        end
                    end
                end

                default: begin
                    state       <= PLL_RST;
                    cnt         <= '0;
                    pll_reset_n <= 1'b0;
                    sys_reset_n <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pll_reset_seq.md
Name: pll_reset_seq

Overview:
- Sequences the reset and lock behaviour of the clock-generation PLL, which is the 100 MHz → 20 MHz SB_PLL40_CORE wrapper.
- Drives the PLL's active-low reset, watches its asynchronous lock output, and releases a system reset only after the lock has been stable for a set time.
- Restarts the PLL on lock timeout or lock loss, and keeps saturating counts of both events for status reporting.
- Runs on the PLL reference clock (100 MHz), so it keeps running while the PLL output is dead. Downstream 20 MHz logic resynchronises sys_reset_n locally.

Parameters:
- HOLD_CYCLES, 16: number of cycles pll_reset_n is held low per PLL restart (≥1).
- LOCK_TIMEOUT, 10000: cycles allowed in WAIT_LOCK before a restart (100 µs at 100 MHz).
- STABLE_CYCLES, 1024: consecutive cycles locked must stay high before sys_reset_n is released (≥1).
- SYNC_STAGES, 2: flops in the locked synchroniser (≥2).
- CNT_W, 8: width of the event counters.

Ports:
- clock, input, 1: reference clock, 100 MHz.
- reset_n, input, 1: asynchronous active-low reset.
- locked, input, 1: PLL lock, asynchronous to clock.
- soft_restart, input, 1: synchronous single-cycle request to restart the PLL.
- pll_reset_n, output, 1: to PLL RESETB; low = PLL held in reset.
- sys_reset_n, output, 1: system reset, active-low. Asserts asynchronously; deasserts synchronously.
- state, output, 2: current FSM state (encoding below).
- timeout_count, output, CNT_W: saturating count of lock timeouts.
- loss_count, output, CNT_W: saturating count of lock losses seen in RUN.

Behaviour:
- Decided: one clock; reset is asynchronous and active-low (reset_n).
- While reset_n is low, all registers clear asynchronously:
  - state = PLL_RST, pll_reset_n = 0, sys_reset_n = 0;
  - both counters = 0; synchroniser = 0; internal cycle counter = 0.
- locked passes through SYNC_STAGES flops to give locked_s. Only locked_s is used in the FSM.
- State encoding: PLL_RST = 0, WAIT_LOCK = 1, STABLE = 2, RUN = 3. All outputs are registered.
- PLL_RST:
  - pll_reset_n = 0, sys_reset_n = 0; counter increments each cycle.
  - When counter = HOLD_CYCLES-1: go to WAIT_LOCK, clear counter, set pll_reset_n = 1 on the same edge.
- WAIT_LOCK:
  - If locked_s = 1: go to STABLE, counter = 0.
  - Else, if counter = LOCK_TIMEOUT-1: go to PLL_RST, counter = 0, pll_reset_n = 0, timeout_count +1 (saturating).
  - Else: counter +1.
- STABLE:
  - If locked_s = 0: go to WAIT_LOCK, counter = 0. This is not counted as a loss.
  - Else, if counter = STABLE_CYCLES-1: go to RUN, sys_reset_n = 1.
  - Else: counter +1.
- RUN:
  - If locked_s = 0: go to PLL_RST, counter = 0, sys_reset_n = 0, pll_reset_n = 0, loss_count +1 (saturating).
- Latency from an uninterrupted rise of locked (first edge at which stage 1 samples 1 = edge e0):
  - state = STABLE after edge e0+SYNC_STAGES;
  - sys_reset_n rises at edge e0+SYNC_STAGES+STABLE_CYCLES.
- Lock loss in RUN, first sampled low at edge e0: sys_reset_n falls at edge e0+SYNC_STAGES.
- soft_restart = 1 in any state: go to PLL_RST, counter = 0, pll_reset_n = 0, sys_reset_n = 0. No counter is incremented. It takes priority over every other transition in the same cycle.
- Glitches on locked shorter than 1 cycle are only filtered by sampling. A low locked_s for one cycle in RUN is still a loss.
- Counters hold at 2^CNT_W-1 and never wrap.
- An assertion of reset_n in the middle of a sequence aborts immediately. The sequence restarts from PLL_RST with a full HOLD_CYCLES.
- Internal counter width = clog2 of the maximum of HOLD_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES. There is no overflow because each state compares against its own limit.

Decomposition:
- Package pll_seq_pkg holds:
  - the state encoding constants (PLL_RST, WAIT_LOCK, STABLE, RUN);
  - a function computing the counter width.
- One natural sub-module: sync_ff, an N-stage synchroniser with asynchronous active-low clear, used for locked.
- Counters and FSM stay in the top module.

Test Plan:
Bench parameters: HOLD_CYCLES=4, LOCK_TIMEOUT=50, STABLE_CYCLES=8, SYNC_STAGES=2, CNT_W=4.
- Reset release with locked = 0:
  - pll_reset_n = 0 for exactly 4 cycles, then 1; state = 1.
  - At 50 cycles later: pll_reset_n = 0, timeout_count = 1, state = 0.
- Normal lock:
  - locked rises 10 cycles into WAIT_LOCK and is held.
  - sys_reset_n rises exactly 10 edges after locked is first sampled; state = 3.
- Glitch during STABLE:
  - locked low for 3 cycles at STABLE count 5 → state returns to 1, loss_count = 0.
  - After re-lock, a full 8-cycle stable window is required before sys_reset_n = 1.
- Loss in RUN:
  - locked falls → sys_reset_n = 0 two edges later, loss_count = 1, pll_reset_n low for 4 cycles.
  - After re-lock, sys_reset_n returns to 1.
- Saturation and priority:
  - 20 forced timeouts → timeout_count holds 15.
  - soft_restart in RUN with locked = 0 in the same cycle → state = 0, loss_count unchanged.
- Asynchronous reset in RUN:
  - reset_n low between clock edges → sys_reset_n and pll_reset_n go 0 immediately, counters = 0.
  - After release, a full sequence repeats.
